// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control path.
// Holds the state encoding, button indices and the press-event priority helper.
package stopwatch_pkg;

   localparam int NUM_BTNS         = 5;
   localparam int DEFAULT_TICK_DIV = 100000;

   localparam int BTN_START = 0;
   localparam int BTN_LAP   = 1;
   localparam int BTN_CLEAR = 2;
   localparam int BTN_MODE  = 3;
   localparam int BTN_LOCK  = 4;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'b00,
      ST_RUNNING  = 2'b01,
      ST_PAUSED   = 2'b10,
      ST_LAP_HOLD = 2'b11
   } sw_state_t;

   typedef enum logic [2:0] {
      EV_NONE,
      EV_CLEAR,
      EV_START,
      EV_LAP,
      EV_MODE
   } sw_evt_t;

   // Single winning event per cycle: CLEAR > START > LAP > MODE; LOCK level mutes everything.
   function automatic sw_evt_t pick_event(input logic [NUM_BTNS-1:0] rise,
                                          input logic                lock);
      logic [NUM_BTNS-1:0] valid;
      sw_evt_t             evt;
      valid = lock ? '0 : rise;
      evt   = EV_NONE;
      if (valid != '0) begin
         if (valid[BTN_CLEAR])      evt = EV_CLEAR;
         else if (valid[BTN_START]) evt = EV_START;
         else if (valid[BTN_LAP])   evt = EV_LAP;
         else if (valid[BTN_MODE])  evt = EV_MODE;
      end
      return evt;
   endfunction

   function automatic logic is_active(input sw_state_t st);
      return (st == ST_RUNNING) || (st == ST_LAP_HOLD);
   endfunction

endpackage

// File: rtl/btn_edge_detect.sv
// Registered rising-edge detector for debounced button levels.
// History resets to all ones so buttons held through reset never produce a press.
module btn_edge_detect #(
   parameter int NUM_BTN = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_BTN-1:0] btn_db,
   output logic [NUM_BTN-1:0] rise
);

   logic [NUM_BTN-1:0] btn_q;

   always_ff @(posedge clk) begin
      if (rst) btn_q <= '1;
      else     btn_q <= btn_db;
   end

   assign rise = btn_db & ~btn_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing FSM: button events in, timebase tick and clear/lap strobes out.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   IDLE     | stopped at zero, MODE selects which value is displayed
//   RUNNING  | counting, live time displayed
//   PAUSED   | counting frozen, prescaler keeps its partial period
//   LAP_HOLD | counting continues, display frozen on the captured lap
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int TICK_DIV = DEFAULT_TICK_DIV,
   parameter int NUM_BTN  = NUM_BTNS
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_BTN-1:0] btn_db,
   output logic               tick_en,
   output logic               clr,
   output logic               lap_latch,
   output logic               disp_lap,
   output logic               running,
   output logic [1:0]         state_o
);

   localparam int               PW       = $clog2(TICK_DIV);
   localparam logic [PW-1:0]    PRE_LAST = PW'(TICK_DIV - 1);

   sw_state_t          state;
   logic [PW-1:0]      prescaler;
   logic               view_sel;
   logic [NUM_BTN-1:0] rise;
   sw_evt_t            evt;

   btn_edge_detect #(.NUM_BTN(NUM_BTN)) u_edge (
      .clk    (clk),
      .rst    (rst),
      .btn_db (btn_db),
      .rise   (rise)
   );

   assign evt = pick_event(rise, btn_db[BTN_LOCK]);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         prescaler <= '0;
         view_sel  <= 1'b0;
         clr       <= 1'b0;
         lap_latch <= 1'b0;
      end else begin
         clr       <= 1'b0;
         lap_latch <= 1'b0;

         if (is_active(state))
            prescaler <= (prescaler == PRE_LAST) ? '0 : prescaler + 1'b1;

         case (state)
            ST_IDLE: begin
               case (evt)
                  EV_START: state <= ST_RUNNING;
                  EV_CLEAR: begin
                     clr      <= 1'b1;
                     view_sel <= 1'b0;
                  end
                  EV_MODE:  view_sel <= ~view_sel;
                  default:  ;
               endcase
            end
            ST_RUNNING: begin
               case (evt)
                  EV_START: state <= ST_PAUSED;
                  EV_LAP: begin
                     state     <= ST_LAP_HOLD;
                     lap_latch <= 1'b1;
                  end
                  default:  ;
               endcase
            end
            ST_LAP_HOLD: begin
               case (evt)
                  EV_LAP:   state <= ST_RUNNING;
                  EV_START: begin
                     // Pausing from a lap keeps the captured lap on screen.
                     state    <= ST_PAUSED;
                     view_sel <= 1'b1;
                  end
                  default:  ;
               endcase
            end
            ST_PAUSED: begin
               case (evt)
                  EV_START: begin
                     state    <= ST_RUNNING;
                     view_sel <= 1'b0;
                  end
                  EV_CLEAR: begin
                     state     <= ST_IDLE;
                     clr       <= 1'b1;
                     prescaler <= '0;
                     view_sel  <= 1'b0;
                  end
                  EV_MODE:  view_sel <= ~view_sel;
                  default:  ;
               endcase
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign running = is_active(state);
   assign tick_en = running && (prescaler == PRE_LAST);
   assign state_o = state;

   always_comb begin
      disp_lap = view_sel;
      if (state == ST_LAP_HOLD)     disp_lap = 1'b1;
      else if (state == ST_RUNNING) disp_lap = 1'b0;
   end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with TICK_DIV=4: directed walk then random buttons.
// A cycle-level behavioural model predicts every output after each clock edge.
module tb_stopwatch_ctrl;

   localparam int TD = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [4:0] btn_db = 5'b0;
   logic       tick_en, clr, lap_latch, disp_lap, running;
   logic [1:0] state_o;

   int n_checks = 0;
   int n_errors = 0;

   // model: states use the published 2-bit codes (0 idle, 1 run, 2 pause, 3 lap hold)
   int         m_state;
   int         m_run_cycles;   // running cycles since last zeroing, mod TD
   bit         m_view;
   bit [4:0]   m_prev;
   bit         m_clr, m_lap;

   stopwatch_ctrl #(.TICK_DIV(TD), .NUM_BTN(5)) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_db    (btn_db),
      .tick_en   (tick_en),
      .clr       (clr),
      .lap_latch (lap_latch),
      .disp_lap  (disp_lap),
      .running   (running),
      .state_o   (state_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit m_active();
      return (m_state == 1) || (m_state == 3);
   endfunction

   task automatic model_reset();
      m_state      = 0;
      m_run_cycles = 0;
      m_view       = 1'b0;
      m_prev       = 5'b11111;
      m_clr        = 1'b0;
      m_lap        = 1'b0;
   endtask

   // advance the model by one edge with buttons b applied before it
   task automatic model_step(input bit [4:0] b);
      bit [4:0] r;
      string    ev;
      r = b & ~m_prev;
      m_prev = b;
      if (b[4]) r = 5'b0;
      if (r[2])      ev = "clear";
      else if (r[0]) ev = "start";
      else if (r[1]) ev = "lap";
      else if (r[3]) ev = "mode";
      else           ev = "none";
      m_clr = 1'b0;
      m_lap = 1'b0;
      if (m_active()) m_run_cycles = (m_run_cycles + 1) % TD;
      case (m_state)
         0: begin
            if (ev == "start") m_state = 1;
            else if (ev == "clear") begin m_clr = 1'b1; m_view = 1'b0; end
            else if (ev == "mode") m_view = ~m_view;
         end
         1: begin
            if (ev == "start") m_state = 2;
            else if (ev == "lap") begin m_state = 3; m_lap = 1'b1; end
         end
         3: begin
            if (ev == "lap") m_state = 1;
            else if (ev == "start") begin m_state = 2; m_view = 1'b1; end
         end
         default: begin
            if (ev == "start") begin m_state = 1; m_view = 1'b0; end
            else if (ev == "clear") begin
               m_state = 0; m_clr = 1'b1; m_run_cycles = 0; m_view = 1'b0;
            end
            else if (ev == "mode") m_view = ~m_view;
         end
      endcase
   endtask

   task automatic compare_all();
      bit exp_disp;
      exp_disp = (m_state == 3) ? 1'b1 : (m_state == 1) ? 1'b0 : m_view;
      chk("state_o",   32'(state_o),   32'(m_state));
      chk("running",   32'(running),   32'(m_active()));
      chk("tick_en",   32'(tick_en),   32'(m_active() && m_run_cycles == TD - 1));
      chk("clr",       32'(clr),       32'(m_clr));
      chk("lap_latch", 32'(lap_latch), 32'(m_lap));
      chk("disp_lap",  32'(disp_lap),  32'(exp_disp));
   endtask

   task automatic cycle(input logic [4:0] b);
      btn_db = b;
      @(posedge clk);
      model_step(b);
      #1;
      compare_all();
   endtask

   task automatic do_reset(input logic [4:0] b);
      btn_db = b;
      rst    = 1'b1;
      @(posedge clk);
      model_reset();
      #1;
      rst = 1'b0;
      compare_all();
   endtask

   initial begin
      bit [4:0] cur;
      model_reset();

      // START held through reset, released: nothing happens
      do_reset(5'b00001);
      cycle(5'b00001);
      chk("hold_thru_reset", 32'(state_o), 32'd0);
      repeat (10) cycle(5'b00000);
      chk("idle_after_release", 32'(state_o), 32'd0);

      // start, tick cadence
      cycle(5'b00001);
      chk("start_to_run", 32'(state_o), 32'd1);
      chk("no_tick_at_entry", 32'(tick_en), 32'd0);
      cycle(5'b00000);
      cycle(5'b00000);
      cycle(5'b00000);
      chk("first_tick", 32'(tick_en), 32'd1);
      cycle(5'b00000);
      chk("tick_single", 32'(tick_en), 32'd0);

      // pause with prescaler at 2, resume continues the partial period
      cycle(5'b00000);
      cycle(5'b00001);
      chk("pause", 32'(state_o), 32'd2);
      repeat (3) begin
         cycle(5'b00000);
         chk("no_tick_paused", 32'(tick_en), 32'd0);
      end
      cycle(5'b00001);
      chk("resume", 32'(state_o), 32'd1);
      chk("resume_no_tick", 32'(tick_en), 32'd0);
      cycle(5'b00000);
      chk("resume_tick", 32'(tick_en), 32'd1);

      // lap capture and release
      cycle(5'b00000);
      cycle(5'b00010);
      chk("lap_strobe", 32'(lap_latch), 32'd1);
      chk("lap_state", 32'(state_o), 32'd3);
      chk("lap_disp", 32'(disp_lap), 32'd1);
      cycle(5'b00000);
      chk("lap_strobe_off", 32'(lap_latch), 32'd0);
      cycle(5'b00000);
      chk("lap_ticks_continue", 32'(tick_en), 32'd1);
      cycle(5'b00000);
      cycle(5'b00010);
      chk("lap_release", 32'(state_o), 32'd1);
      chk("lap_release_disp", 32'(disp_lap), 32'd0);
      chk("lap_release_nocap", 32'(lap_latch), 32'd0);

      // CLEAR+START together while paused: CLEAR wins
      cycle(5'b00000);
      cycle(5'b00001);
      cycle(5'b00000);
      cycle(5'b00101);
      chk("clear_wins", 32'(state_o), 32'd0);
      chk("clear_strobe", 32'(clr), 32'd1);
      cycle(5'b00000);
      chk("clear_strobe_off", 32'(clr), 32'd0);

      // CLEAR ignored while running
      cycle(5'b00001);
      cycle(5'b00000);
      cycle(5'b00100);
      chk("clear_ign_state", 32'(state_o), 32'd1);
      cycle(5'b00000);
      chk("clear_ign_strobe", 32'(clr), 32'd0);
      cycle(5'b00001);
      cycle(5'b00000);
      cycle(5'b00100);
      cycle(5'b00000);
      chk("back_to_idle", 32'(state_o), 32'd0);

      // LOCK masks a press that stays held past unlock
      cycle(5'b10000);
      cycle(5'b10001);
      cycle(5'b00001);
      chk("lock_mask", 32'(state_o), 32'd0);
      cycle(5'b00000);
      chk("mode_before", 32'(disp_lap), 32'd0);
      cycle(5'b01000);
      chk("mode_toggle", 32'(disp_lap), 32'd1);
      cycle(5'b00000);

      // random buttons against the model, with occasional mid-run resets
      cur = 5'b0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(299) == 0) begin
            do_reset(cur);
         end else begin
            for (int k = 0; k < 4; k++)
               if ($urandom_range(5) == 0) cur[k] = ~cur[k];
            if ($urandom_range(19) == 0) cur[4] = ~cur[4];
            cycle(cur);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control FSM that sequences the stopwatch datapath from the five debounced button levels produced by debounce_wrapper (its results bus).
- Detects presses, applies priority and lock rules, and runs a RUN/PAUSE/LAP/CLEAR state machine.
- Generates the 1/100 s timebase tick plus single-cycle clear and lap-capture strobes for the time counter and lap register.
- Sits between debounce_wrapper and the time-counter/display blocks.

Parameters:
TICK_DIV, 100000, clk cycles per timebase tick (100000 at 10 MHz gives 10 ms); minimum 2
NUM_BTN, 5, button count; fixed at 5, present for port sizing only

Ports:
clk  in  1  system clock, single domain
rst  in  1  synchronous reset, active-high
btn_db  in  NUM_BTN  debounced levels, 1 = pressed; [0]=START_STOP [1]=LAP [2]=CLEAR [3]=MODE [4]=LOCK
tick_en  out  1  one-cycle timebase pulse to the time counter
clr  out  1  one-cycle pulse: zero time counter and lap register
lap_latch  out  1  one-cycle pulse: copy current time into lap register
disp_lap  out  1  level: display shows lap register (1) or live time (0)
running  out  1  level: 1 in RUNNING or LAP_HOLD
state_o  out  2  current state encoding

Behaviour:
- Clock and reset: one clock (clk); rst is synchronous, active-high, sampled on the rising edge of clk.
- Reset:
  - state=IDLE, prescaler=0, view_sel=0.
  - tick_en, clr, lap_latch = 0.
  - btn_q <= all ones, so buttons already held at reset produce no event.
- Edge detect:
  - btn_q registers btn_db every cycle; rise = btn_db & ~btn_q.
  - The FSM consumes rise on the same edge that updates btn_q. One event per press; release produces nothing.
- LOCK: while btn_db[4]=1, all press events are discarded. btn_q still tracks, so a press made under LOCK never fires after LOCK releases.
- Priority when several rises occur in one cycle: CLEAR > START_STOP > LAP > MODE. Only the highest valid event acts; the others are dropped.
- States (2-bit encoding, in stopwatch_pkg): IDLE=00, RUNNING=01, PAUSED=10, LAP_HOLD=11.
- Transitions; any event not listed is ignored:
  - IDLE:
    - START -> RUNNING.
    - CLEAR -> IDLE, with clr pulse and view_sel<=0.
    - MODE toggles view_sel.
  - RUNNING:
    - START -> PAUSED.
    - LAP -> LAP_HOLD, with lap_latch pulse.
    - CLEAR and MODE are ignored.
  - LAP_HOLD:
    - LAP -> RUNNING; display releases, no capture.
    - START -> PAUSED, with view_sel<=1.
    - CLEAR is ignored.
  - PAUSED:
    - START -> RUNNING, with view_sel<=0.
    - CLEAR -> IDLE, with clr pulse, prescaler<=0, view_sel<=0.
    - MODE toggles view_sel.
- Strobe timing: clr and lap_latch are registered. Each is high for exactly the one cycle after the edge that accepted the event, then 0.
- Prescaler:
  - Width $clog2(TICK_DIV).
  - Increments each cycle while the registered state is RUNNING or LAP_HOLD; wraps TICK_DIV-1 -> 0.
  - tick_en is combinational: (state in {RUNNING, LAP_HOLD}) && prescaler == TICK_DIV-1.
  - Holds its value in PAUSED, so resume continues the partial period. Zeroed only by reset or by CLEAR.
  - First tick after a START from IDLE arrives TICK_DIV cycles after the state becomes RUNNING.
- disp_lap:
  - 1 in LAP_HOLD.
  - 0 in RUNNING.
  - Equals view_sel in IDLE and PAUSED.
- running and state_o decode combinationally from the state register.
- Reset mid-operation: on the next edge all state returns to reset values; no clr pulse is generated by reset.

Decomposition:
- stopwatch_pkg holds:
  - state enum sw_state_t with the fixed 2-bit encodings;
  - button index localparams BTN_START=0, BTN_LAP=1, BTN_CLEAR=2, BTN_MODE=3, BTN_LOCK=4;
  - DEFAULT_TICK_DIV.
- One sub-module: btn_edge_detect, a NUM_BTN-wide registered rise detector with reset-to-ones. It is shared later by the mode/set-time logic.

Test Plan (TICK_DIV=4):
1. Reset with btn_db=5'b00001 held, release, wait 10 cycles -> state_o=00, tick_en never high, no strobes.
2. START press from IDLE -> state_o=01 one edge later. tick_en pulses every 4th cycle, first pulse 4 cycles after entering RUNNING. START again -> 10, tick_en stays 0.
3. Pause with prescaler=2, START to resume -> first tick_en exactly 2 cycles after resume.
4. RUNNING, LAP press -> lap_latch high exactly 1 cycle, state_o=11, disp_lap=1, ticks continue. LAP again -> state_o=01, disp_lap=0, no lap_latch.
5. PAUSED with btn_db rising CLEAR+START in the same cycle -> state_o=00, clr high 1 cycle, prescaler=0. Same CLEAR while RUNNING -> ignored, clr stays 0.
6. LOCK held, START pressed then LOCK released while START still held -> state stays 00, no events. MODE press in IDLE -> disp_lap toggles 0->1.
